full_adder_reg: RTL and testbench



---
 rtl/full_adder_reg.sv | 87 ++++++++
 tb/tb_full_adder_reg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/full_adder_reg.sv
// Ripple-carry adder of 1-bit full-adder cells with sum, carry-out and signed overflow.
// Latency 1 cycle (REG_OUT=1) or 0 (REG_OUT=0); no backpressure, each valid input overwrites the result.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module full_adder_reg #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             ovf_c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum_c[i]),
            .cout (c[i+1])
        );
    end

    assign carry_c = c[WIDTH];
    // Carry into the MSB differing from carry out of it marks signed overflow.
    assign ovf_c   = c[WIDTH] ^ c[WIDTH-1];

    if (REG_OUT != 0) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             ovf_q;
        logic             vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
                vld_q   <= 1'b0;
            end else begin
                vld_q <= in_valid;
                // Data registers only load on valid, so idle-cycle inputs never reach them.
                if (in_valid) begin
                    sum_q   <= sum_c;
                    carry_q <= carry_c;
                    ovf_q   <= ovf_c;
                end
            end
        end

        assign sum       = sum_q;
        assign carry     = carry_q;
        assign overflow  = ovf_q;
        assign out_valid = vld_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign sum       = sum_c;
        assign carry     = carry_c;
        assign overflow  = ovf_c;
        assign out_valid = in_valid;
    end
endmodule

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg: WIDTH=1 and WIDTH=8 registered, WIDTH=1 combinational.

module tb_full_adder_reg;
    logic clk;
    logic rst_n;

    logic       vld1, cin1;
    logic [0:0] a1, b1, sum1;
    logic       carry1, ovf1, ovld1;

    logic       vld8, cin8;
    logic [7:0] a8, b8, sum8;
    logic       carry8, ovf8, ovld8;

    logic       vldc, cinc;
    logic [0:0] ac, bc, sumc;
    logic       carryc, ovfc, ovldc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t v1[8];
    vec_t v8[6];

    full_adder_reg #(.WIDTH(1), .REG_OUT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld1), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .carry(carry1), .overflow(ovf1), .out_valid(ovld1)
    );

    full_adder_reg #(.WIDTH(8), .REG_OUT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .carry(carry8), .overflow(ovf8), .out_valid(ovld8)
    );

    full_adder_reg #(.WIDTH(1), .REG_OUT(0)) dutc (
        .clk(clk), .rst_n(rst_n), .in_valid(vldc), .a(ac), .b(bc), .cin(cinc),
        .sum(sumc), .carry(carryc), .overflow(ovfc), .out_valid(ovldc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // a, b, cin -> sum, carry, overflow
        v1[0] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0};
        v1[1] = '{8'h0, 8'h0, 1'b1, 8'h1, 1'b0, 1'b1};
        v1[2] = '{8'h0, 8'h1, 1'b0, 8'h1, 1'b0, 1'b0};
        v1[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1, 1'b0};
        v1[4] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1'b0};
        v1[5] = '{8'h1, 8'h0, 1'b1, 8'h0, 1'b1, 1'b0};
        v1[6] = '{8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1'b1};
        v1[7] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1, 1'b0};

        v8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        v8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        v8[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        v8[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        v8[4] = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        v8[5] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

        rst_n = 1'b0;
        vld1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        vld8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        vldc = 1'b0; ac = '0; bc = '0; cinc = 1'b0;

        // Reset state
        #2;
        chk("rst_w1_sum", sum1, 0);
        chk("rst_w1_carry", carry1, 0);
        chk("rst_w1_vld", ovld1, 0);
        chk("rst_w8_sum", sum8, 0);
        chk("rst_w8_ovf", ovf8, 0);
        chk("rst_w8_vld", ovld8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 exhaustive walk, back-to-back
        for (int i = 0; i < 8; i++) begin
            vld1 = 1'b1; a1 = v1[i].a[0]; b1 = v1[i].b[0]; cin1 = v1[i].cin;
            @(negedge clk);
            chk($sformatf("w1_sum[%0d]", i), sum1, v1[i].s[0]);
            chk($sformatf("w1_carry[%0d]", i), carry1, v1[i].co);
            chk($sformatf("w1_ovf[%0d]", i), ovf1, v1[i].ov);
            chk($sformatf("w1_vld[%0d]", i), ovld1, 1);
        end

        // WIDTH=1 hold while in_valid=0
        vld1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        @(negedge clk);
        chk("hold_load_vld", ovld1, 1);
        vld1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_sum[%0d]", i), sum1, 0);
            chk($sformatf("hold_carry[%0d]", i), carry1, 1);
            chk($sformatf("hold_ovf[%0d]", i), ovf1, 1);
            chk($sformatf("hold_vld[%0d]", i), ovld1, 0);
        end

        // WIDTH=8 vectors, back-to-back
        for (int i = 0; i < 6; i++) begin
            vld8 = 1'b1; a8 = v8[i].a; b8 = v8[i].b; cin8 = v8[i].cin;
            @(negedge clk);
            chk($sformatf("w8_sum[%0d]", i), sum8, v8[i].s);
            chk($sformatf("w8_carry[%0d]", i), carry8, v8[i].co);
            chk($sformatf("w8_ovf[%0d]", i), ovf8, v8[i].ov);
            chk($sformatf("w8_vld[%0d]", i), ovld8, 1);
        end

        // Mid-cycle asynchronous reset with a live nonzero result
        vld8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        @(negedge clk);
        chk("pre_rst_sum", sum8, 8'h80);
        chk("pre_rst_vld", ovld8, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", sum8, 0);
        chk("arst_carry", carry8, 0);
        chk("arst_ovf", ovf8, 0);
        chk("arst_vld", ovld8, 0);
        // Clock edge during reset with valid input must not load
        @(negedge clk);
        chk("in_rst_sum", sum8, 0);
        chk("in_rst_vld", ovld8, 0);
        rst_n = 1'b1;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        @(negedge clk);
        chk("post_rst_sum", sum8, 8'h47);
        chk("post_rst_vld", ovld8, 1);
        vld8 = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_vld", ovld8, 0);
        chk("post_rst_idle_sum", sum8, 8'h47);

        // Combinational variant, no clock edge involved
        @(posedge clk);
        #2;
        vldc = 1'b1; ac = 1'b1; bc = 1'b0; cinc = 1'b1;
        #1;
        chk("comb_sum", sumc, 0);
        chk("comb_carry", carryc, 1);
        chk("comb_ovf", ovfc, 0);
        chk("comb_vld", ovldc, 1);
        vldc = 1'b0; ac = 1'b1; bc = 1'b1; cinc = 1'b1;
        #1;
        chk("comb_vld_low", ovldc, 0);
        chk("comb_sum2", sumc, 1);
        chk("comb_carry2", carryc, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
